// File: rtl/seq_detector_param_pkg.sv
// Shared state encodings for the pattern detector.
package seq_det_pkg;
  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_HUNT = 2'b10
  } state_e;

  // 2'b11 is unused and treated as IDLE
  function automatic state_e st_decode(input logic [ST_W-1:0] raw);
    case (raw)
      2'b01:   return ST_FILL;
      2'b10:   return ST_HUNT;
      default: return ST_IDLE;
    endcase
  endfunction
endpackage

// File: rtl/seq_detector_param_if.sv
// Symbol stream in, match/status out.
interface seq_detector_param_if #(
  parameter int SYM_W   = 2,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic                     clear;
  logic [SYM_W-1:0]         i;
  logic                     i_valid;
  logic [PAT_LEN*SYM_W-1:0] pattern;
  logic                     ovl;
  logic                     y;
  logic [1:0]               s;
  logic [1:0]               n;
  logic [CNT_W-1:0]         match_cnt;
  logic                     cnt_sat;

  modport master (
    output clear, i, i_valid, pattern, ovl,
    input  y, s, n, match_cnt, cnt_sat
  );

  modport slave (
    input  clear, i, i_valid, pattern, ovl,
    output y, s, n, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with sticky all-ones flag.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);
  logic [W-1:0] q_inc;

  assign q_inc = q + W'(1);

  // count up on inc, stop at all-ones; sat sets on the step that lands there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (inc && !(&q)) begin
      q <= q_inc;
      if (&q_inc) sat <= 1'b1;
    end
  end
endmodule

// File: rtl/seq_detector_param.sv
// Programmable PAT_LEN-symbol pattern detector with overlap control.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int SYM_W   = 2,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_detector_param_if.slave   bus
);
  localparam int WIN_W = PAT_LEN * SYM_W;
  localparam int FW    = $clog2(PAT_LEN + 1);

  logic [WIN_W-1:0] window, win_nxt;
  logic [FW-1:0]    fill, fill_nxt;
  state_e           st, st_cur, st_nxt;
  logic             accept, full_nxt, hit, y_q;

  assign accept   = bus.i_valid & ~bus.clear;
  assign win_nxt  = {window[WIN_W-SYM_W-1:0], bus.i};
  // this accept brings the window to PAT_LEN valid symbols
  assign full_nxt = (fill >= FW'(PAT_LEN - 1));
  assign hit      = accept & full_nxt & (win_nxt == bus.pattern);
  assign st_cur   = st_decode(st);

  // next fill / next state; clear beats everything, idle cycles hold
  always_comb begin
    fill_nxt = fill;
    st_nxt   = st_cur;
    if (bus.clear) begin
      fill_nxt = '0;
      st_nxt   = ST_IDLE;
    end else if (accept) begin
      if (hit && !bus.ovl) begin
        fill_nxt = '0;
        st_nxt   = ST_FILL;
      end else if (full_nxt) begin
        fill_nxt = FW'(PAT_LEN);
        st_nxt   = ST_HUNT;
      end else begin
        fill_nxt = fill + FW'(1);
        st_nxt   = ST_FILL;
      end
    end
  end

  // FSM state, window shift register and registered match pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= ST_IDLE;
      fill   <= '0;
      window <= '0;
      y_q    <= 1'b0;
    end else begin
      st   <= st_nxt;
      fill <= fill_nxt;
      y_q  <= hit;
      if (accept) window <= win_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.clear),
    .inc (hit),
    .q   (bus.match_cnt),
    .sat (bus.cnt_sat)
  );

  assign bus.y = y_q;
  assign bus.s = st;
  assign bus.n = st_nxt;
endmodule
